// File: rtl/rx_frame_if.sv
// rx_frame_if: serial line, configuration, consumer handshake and status of rx_frame_module.
`timescale 1ns/1ps
`default_nettype none

interface rx_frame_if;
  logic       rx;
  logic       stop_bit_config;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx, stop_bit_config, rd_en,
    input  data_out, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    input  rx, stop_bit_config, rd_en,
    output data_out, rx_valid, frame_err, overrun, busy
  );
endinterface

`default_nettype wire

// File: rtl/rx_frame_module.sv
// rx_frame_module: one-bit-per-clock serial frame receiver (start, 8 data LSB first, 1/2 stop).
// Macro RX_FRAME_FIFO_EN selects a 4-entry output FIFO instead of a single holding register.
`timescale 1ns/1ps
`default_nettype none

module rx_frame_module (
  input  wire logic  clk,
  input  wire logic  rst,
  rx_frame_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2,
    BRK  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, rx_s_q, rx_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stop2_q, stop2_d;
  logic       ferr_q;
  logic       ovr_q;
  logic       deliver_w;
  logic       ferr_w;

  // rx_prev_q makes the start condition a genuine 1-to-0 edge of the synchronized line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= bus.rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    stop2_d   = stop2_q;
    deliver_w = 1'b0;
    ferr_w    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q && rx_prev_q) begin
          state_d = DATA;
          cnt_d   = 3'd0;
          stop2_d = bus.stop_bit_config;
        end
      end
      DATA: begin
        shift_d = {rx_s_q, shift_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // cnt_q counts good stop bits already seen; wraps to 0 on entry from DATA
        if (!rx_s_q) begin
          ferr_w  = 1'b1;
          state_d = BRK;
          cnt_d   = 3'd0;
        end else if (stop2_q && (cnt_q == 3'd0)) begin
          cnt_d   = 3'd1;
        end else begin
          deliver_w = 1'b1;
          state_d   = IDLE;
          cnt_d     = 3'd0;
        end
      end
      BRK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= 8'd0;
      cnt_q   <= 3'd0;
      stop2_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop2_q <= stop2_d;
      ferr_q  <= ferr_w;
    end
  end

`ifdef RX_FRAME_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       pop_w, push_w, full_w;

  assign full_w = (count_q == 3'd4);
  assign pop_w  = bus.rd_en && (count_q != 3'd0);
  assign push_w = deliver_w && (!full_w || pop_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= deliver_w && full_w && !pop_w;
      if (push_w) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push_w, pop_w})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.data_out = mem_q[rd_ptr_q];
  assign bus.rx_valid = (count_q != 3'd0);
`else
  logic [7:0] data_q;
  logic       valid_q;
  logic       pop_w;

  assign pop_w = bus.rd_en && valid_q;

  // A same-cycle pop frees the register, so the delivery is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (deliver_w) begin
        if (!valid_q || pop_w) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (pop_w) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.rx_valid = valid_q;
`endif

  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_module.sv
// tb_rx_frame_module: scoreboard bench for rx_frame_module (either output buffering build).
`timescale 1ns/1ps
`default_nettype none

module tb_rx_frame_module;

`ifdef RX_FRAME_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_if bus ();

  rx_frame_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         auto_pop = 1'b0;
  logic       man_rd   = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
  end

  // Consumer: pops every valid byte while auto_pop is set, recording what it saw
  initial begin
    bus.rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_pop && bus.rx_valid) begin
        got_q.push_back(bus.data_out);
        bus.rd_en = 1'b1;
      end else begin
        bus.rd_en = man_rd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bad: 0 = good frame, 1 = first stop bit 0, 2 = second stop bit 0
  task automatic send(input logic [7:0] b, input logic two, input int bad,
                      input bit expect_good, output int start);
    bus.stop_bit_config = two;
    bus.rx = 1'b0;
    start  = cyc;
    if (expect_good) exp_q.push_back(b);
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      if (i == 3) bus.stop_bit_config = ~two;
      tick();
    end
    bus.rx = (bad == 1) ? 1'b0 : 1'b1;
    tick();
    if (two) begin
      bus.rx = (bad == 2) ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  task automatic wait_valid(input int start, output int lat);
    int n;
    lat = -1;
    n   = 0;
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      if (bus.rx_valid) lat = cyc - start;
      n++;
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.rx_valid},  32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy},      32'd0);
    chk({tag, "_data"},  {24'd0, bus.data_out},  32'd0);
    chk({tag, "_ferr"},  {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_ovr"},   {31'd0, bus.overrun},   32'd0);
  endtask

  initial begin
    int         st, lat, f0, o0;
    logic [7:0] b2b [4];
    logic [7:0] v;
    b2b = '{8'h01, 8'h80, 8'hFF, 8'h00};
    bus.rx = 1'b1;
    bus.stop_bit_config = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (6) tick();

    // Single frame, one stop bit
    auto_pop = 1'b1;
    f0 = ferr_cnt;
    send(8'hA5, 1'b0, 0, 1'b1, st);
    wait_valid(st, lat);
    chk("t1_latency", lat, 32'd12);
    chk("t1_data", {24'd0, bus.data_out}, 32'h A5);
    repeat (4) tick();
    chk("t1_ferr", ferr_cnt - f0, 32'd0);
    drain("t1");

    // Two stop bits, good then bad second stop
    send(8'h3C, 1'b1, 0, 1'b1, st);
    wait_valid(st, lat);
    chk("t2_latency", lat, 32'd13);
    chk("t2_data", {24'd0, bus.data_out}, 32'h3C);
    repeat (3) tick();
    f0 = ferr_cnt;
    send(8'h81, 1'b1, 2, 1'b0, st);
    repeat (8) tick();
    chk("t2_brk_busy", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    repeat (5) tick();
    chk("t2_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("t2_ferr_pulses", ferr_cnt - f0, 32'd1);
    drain("t2");

    // Back-to-back frames with no idle gap
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    for (int k = 0; k < 4; k++) send(b2b[k], 1'b0, 0, 1'b1, st);
    repeat (20) tick();
    chk("t3_ferr", ferr_cnt - f0, 32'd0);
    chk("t3_ovr", ovr_cnt - o0, 32'd0);
    drain("t3");

    // Overrun with no consumer
    auto_pop = 1'b0;
    o0 = ovr_cnt;
    for (int k = 0; k <= DEPTH; k++) begin
      v = 8'h10 + 8'(k * 17);
      send(v, 1'b0, 0, (k < DEPTH), st);
    end
    repeat (20) tick();
    chk("t4_ovr_pulses", ovr_cnt - o0, 32'd1);
    chk("t4_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t4_head", {24'd0, bus.data_out}, {24'd0, exp_q[0]});
    auto_pop = 1'b1;
    repeat (12) tick();
    drain("t4");

    // Reset in the middle of a frame
    bus.stop_bit_config = 1'b0;
    v = 8'h5A;
    bus.rx = 1'b0;
    tick();
    for (int i = 0; i <= 4; i++) begin
      bus.rx = v[i];
      tick();
    end
    rst = 1'b1;
    #2;
    chk_all_zero("t5_in_reset");
    bus.rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("t5_post_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("t5_post_busy", {31'd0, bus.busy}, 32'd0);
    drain("t5_none");
    send(8'h5A, 1'b0, 0, 1'b1, st);
    repeat (16) tick();
    drain("t5");

    // Delivery and pop in the same cycle
    auto_pop = 1'b0;
    o0 = ovr_cnt;
    for (int k = 0; k < DEPTH; k++) send(8'hC0 + 8'(k), 1'b0, 0, 1'b1, st);
    send(8'h96, 1'b0, 0, 1'b1, st);
    tick();
    man_rd = 1'b1;
    @(negedge clk);
    chk("t6_old_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t6_old_head", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
    tick();
    man_rd = 1'b0;
    @(negedge clk);
    chk("t6_new_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t6_new_head", {24'd0, bus.data_out}, {24'd0, exp_q[0]});
    repeat (4) tick();
    chk("t6_ovr", ovr_cnt - o0, 32'd0);
    auto_pop = 1'b1;
    repeat (12) tick();
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rx_frame_module.md
RX_FRAME_MODULE -- requirements
Module: rx_frame_module

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- rx  input  1  serial line, idle high; one bit per clk cycle.
- stop_bit_config  input  1  0: 1 stop bit, 1: 2 stop bits.
- rd_en  input  1  consumer pop/acknowledge of the current byte.
- data_out  output  8  received byte.
- rx_valid  output  1  data_out holds an unread byte.
- frame_err  output  1  one-cycle pulse: a stop bit sampled 0.
- overrun  output  1  one-cycle pulse: a good frame was dropped for lack of space.
- busy  output  1  high while the FSM is not in IDLE.

Function
REQ-002 rx SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized value rx_s.
REQ-003 Frame format SHALL be: start bit 0, 8 data bits LSB first, then 1 or 2 stop bits of value 1. Bits are consecutive, one per clk, with no baud divider.
REQ-004 FSM states SHALL be IDLE, DATA, STOP, BRK.
- IDLE to DATA when rx_s = 0.
- DATA shifts 8 bits using a 3-bit counter, then goes to STOP.
- STOP checks 1 or 2 bits, then goes to IDLE or BRK.
- BRK goes to IDLE on the first cycle rx_s = 1.
REQ-005 stop_bit_config SHALL be captured on the IDLE-to-DATA transition. Changes mid-frame SHALL have no effect on the current frame.
REQ-006 If the start bit is on rx in cycle N, data bits SHALL be on rx in cycles N+1..N+8. Stop bits SHALL be on rx in cycle N+9, and also N+10 when 2 stop bits are configured.
REQ-007 For a good frame, rx_valid SHALL rise in cycle N+12 with 1 stop bit, or N+13 with 2 stop bits.
REQ-008 Any stop bit sampled 0 SHALL cause all of the following:
- the byte is discarded;
- frame_err pulses for 1 cycle in the cycle rx_valid would otherwise have risen;
- the FSM enters BRK.
With 2 stop bits, both SHALL be checked. The first 0 ends the frame immediately.
REQ-009 In IDLE, the FSM SHALL accept a new start bit in the cycle immediately after STOP completes. Back-to-back frames SHALL be received with no gap.
REQ-010 rd_en SHALL be ignored while rx_valid = 0.
REQ-011 A byte delivery and rd_en in the same cycle SHALL both take effect: the pop applies to the old byte and the new byte is stored.
REQ-012 busy SHALL be 0 in IDLE and 1 in DATA, STOP and BRK.

Reset
REQ-013 While rst = 1, the following SHALL hold, with effect independent of clk:
- FSM in IDLE;
- synchronizer flops = 1;
- shift register, counter and data_out = 0;
- rx_valid = 0, frame_err = 0, overrun = 0, busy = 0;
- FIFO pointers and count = 0.
REQ-014 Reset during any state SHALL abandon the partial frame. After release, the FSM SHALL need a fresh 1-to-0 edge on rx_s to start.

Configuration
REQ-015 Macro RX_FRAME_FIFO_EN SHALL select the output buffering.
REQ-016 With RX_FRAME_FIFO_EN defined, good bytes SHALL go to a 4-entry FIFO:
- data_out shows the head entry;
- rx_valid means "not empty";
- rd_en pops the head;
- a write when 4 entries are held and there is no same-cycle pop drops the byte and pulses overrun;
- pointers wrap modulo 4.
REQ-017 Without RX_FRAME_FIFO_EN, data_out SHALL be a single holding register:
- rx_valid is set on delivery and cleared by rd_en;
- a delivery while rx_valid = 1 and rd_en = 0 keeps the old byte and pulses overrun.

Verification
REQ-018 Single frame: after reset, send 0xA5 with 1 stop bit, start bit in cycle 10. Required: rx_valid = 1 in cycle 22, data_out = 0xA5, frame_err = 0.
REQ-019 Two stop bits: stop_bit_config = 1, send 0x3C. Required: rx_valid rises at N+13 and data_out = 0x3C. Then send 0x81 with the second stop bit forced to 0. Required: frame_err pulses once, 0x81 is not delivered, and busy stays high until rx returns to 1.
REQ-020 Back-to-back: send 0x01, 0x80, 0xFF, 0x00 with no gaps and pop each byte on rx_valid. Required: all four bytes are received in order with no errors.
REQ-021 Overrun:
- With no rd_en, send 2 frames. Without the macro, required: data_out = first byte and one overrun pulse.
- With the macro, send 5 frames. Required: 4 bytes buffered in order and one overrun pulse on the 5th.
REQ-022 Reset mid-frame: assert rst at bit 4 of 0x5A, then release with rx held high. Required: all outputs 0 and no byte delivered. A following 0x5A SHALL be received correctly.
REQ-023 Simultaneous events: deliver a byte while asserting rd_en with rx_valid = 1. Required: no overrun, and the new byte is visible the next cycle. With the macro and a full FIFO, the FIFO count SHALL stay 4.
